// File: rtl/lsq_simple.sv
// lsq_simple: in-order load/store queue issuing one dcache access at a time from the head.
module lsq_simple #(
    parameter int DEPTH    = 8,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst_aL,
    output logic                dispatch_ready,
    input  logic                dispatch_valid,
    input  logic                dispatch_is_store,
    input  logic [1:0]          dispatch_width,
    input  logic                dispatch_unsigned,
    input  logic [ROB_ID_W-1:0] dispatch_rob_id,
    input  logic [11:0]         dispatch_imm,
    input  logic                dispatch_base_ready,
    input  logic [ROB_ID_W-1:0] dispatch_base_tag,
    input  logic [31:0]         dispatch_base_val,
    input  logic                dispatch_sdata_ready,
    input  logic [ROB_ID_W-1:0] dispatch_sdata_tag,
    input  logic [31:0]         dispatch_sdata_val,
    input  logic                alu_broadcast_valid,
    input  logic [ROB_ID_W-1:0] alu_broadcast_rob_id,
    input  logic [31:0]         alu_broadcast_reg_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    output logic                mem_req_is_store,
    output logic [1:0]          mem_req_width,
    output logic [31:0]         mem_req_wdata,
    input  logic                mem_resp_valid,
    input  logic [31:0]         mem_resp_data,
    output logic                ld_broadcast_valid,
    output logic [ROB_ID_W-1:0] ld_broadcast_rob_id,
    output logic [31:0]         ld_broadcast_data,
    output logic                st_done_valid,
    output logic [ROB_ID_W-1:0] st_done_rob_id
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] e_valid;

    logic                e_store [DEPTH];
    logic [1:0]          e_width [DEPTH];
    logic                e_uns   [DEPTH];
    logic [ROB_ID_W-1:0] e_rob   [DEPTH];
    logic [11:0]         e_imm   [DEPTH];
    logic                e_b_rdy [DEPTH];
    logic [ROB_ID_W-1:0] e_b_tag [DEPTH];
    logic [31:0]         e_b_val [DEPTH];
    logic                e_s_rdy [DEPTH];
    logic [ROB_ID_W-1:0] e_s_tag [DEPTH];
    logic [31:0]         e_s_val [DEPTH];

    logic        push, pop, head_rdy, b_hit, s_hit;
    logic [31:0] addr, wdata, ld_ext;

    always_comb begin
        dispatch_ready = count < CW'(DEPTH);
        push     = dispatch_valid && dispatch_ready;
        pop      = (state == REQ && mem_req_ready && mem_req_is_store) || (state == WAIT && mem_resp_valid);
        head_rdy = count != '0 && e_valid[head] && e_b_rdy[head] && e_s_rdy[head];
        b_hit    = alu_broadcast_valid && dispatch_base_tag == alu_broadcast_rob_id;
        s_hit    = alu_broadcast_valid && dispatch_sdata_tag == alu_broadcast_rob_id;
        addr     = e_b_val[head] + {{20{e_imm[head][11]}}, e_imm[head]};
        wdata    = e_width[head] == 2'b00 ? {24'b0, e_s_val[head][7:0]} :
                   e_width[head] == 2'b01 ? {16'b0, e_s_val[head][15:0]} : e_s_val[head];
        ld_ext   = e_width[head] == 2'b00 ? {{24{~e_uns[head] & mem_resp_data[7]}}, mem_resp_data[7:0]} :
                   e_width[head] == 2'b01 ? {{16{~e_uns[head] & mem_resp_data[15]}}, mem_resp_data[15:0]} :
                   mem_resp_data;
    end

    // Payload is qualified by e_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_broadcast_valid && !e_b_rdy[i] && e_b_tag[i] == alu_broadcast_rob_id) begin
                e_b_rdy[i] <= 1'b1;
                e_b_val[i] <= alu_broadcast_reg_data;
            end
            if (alu_broadcast_valid && !e_s_rdy[i] && e_s_tag[i] == alu_broadcast_rob_id) begin
                e_s_rdy[i] <= 1'b1;
                e_s_val[i] <= alu_broadcast_reg_data;
            end
        end
        if (push) begin
            e_store[tail] <= dispatch_is_store;
            e_width[tail] <= dispatch_width;
            e_uns[tail]   <= dispatch_unsigned;
            e_rob[tail]   <= dispatch_rob_id;
            e_imm[tail]   <= dispatch_imm;
            e_b_tag[tail] <= dispatch_base_tag;
            e_b_rdy[tail] <= dispatch_base_ready || b_hit;
            e_b_val[tail] <= dispatch_base_ready ? dispatch_base_val : alu_broadcast_reg_data;
            e_s_tag[tail] <= dispatch_sdata_tag;
            e_s_rdy[tail] <= !dispatch_is_store || dispatch_sdata_ready || s_hit;
            e_s_val[tail] <= dispatch_sdata_ready ? dispatch_sdata_val : alu_broadcast_reg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state               <= IDLE;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            e_valid             <= '0;
            mem_req_valid       <= 1'b0;
            mem_req_addr        <= '0;
            mem_req_is_store    <= 1'b0;
            mem_req_width       <= '0;
            mem_req_wdata       <= '0;
            ld_broadcast_valid  <= 1'b0;
            ld_broadcast_rob_id <= '0;
            ld_broadcast_data   <= '0;
            st_done_valid       <= 1'b0;
            st_done_rob_id      <= '0;
        end else begin
            ld_broadcast_valid <= 1'b0;
            st_done_valid      <= 1'b0;
            count              <= count + CW'(push) - CW'(pop);
            if (push) begin
                e_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            case (state)
                IDLE: if (head_rdy) begin
                    state            <= REQ;
                    mem_req_valid    <= 1'b1;
                    mem_req_addr     <= addr;
                    mem_req_is_store <= e_store[head];
                    mem_req_width    <= e_width[head];
                    mem_req_wdata    <= wdata;
                end
                REQ: if (mem_req_ready) begin
                    mem_req_valid  <= 1'b0;
                    state          <= mem_req_is_store ? IDLE : WAIT;
                    st_done_valid  <= mem_req_is_store;
                    st_done_rob_id <= e_rob[head];
                end
                WAIT: if (mem_resp_valid) begin
                    state               <= IDLE;
                    ld_broadcast_valid  <= 1'b1;
                    ld_broadcast_rob_id <= e_rob[head];
                    ld_broadcast_data   <= ld_ext;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsq_simple.sv
// tb_lsq_simple: directed checks of lsq_simple issue order, operand wakeup, extension and reset.
module tb_lsq_simple;
    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic        dispatch_ready, dispatch_valid, dispatch_is_store, dispatch_unsigned;
    logic [1:0]  dispatch_width;
    logic [4:0]  dispatch_rob_id, dispatch_base_tag, dispatch_sdata_tag;
    logic [11:0] dispatch_imm;
    logic        dispatch_base_ready, dispatch_sdata_ready;
    logic [31:0] dispatch_base_val, dispatch_sdata_val;
    logic        alu_broadcast_valid;
    logic [4:0]  alu_broadcast_rob_id;
    logic [31:0] alu_broadcast_reg_data;
    logic        mem_req_valid, mem_req_ready, mem_req_is_store;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [1:0]  mem_req_width;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        ld_broadcast_valid, st_done_valid;
    logic [4:0]  ld_broadcast_rob_id, st_done_rob_id;
    logic [31:0] ld_broadcast_data;
    int checks = 0;
    int failures = 0;

    lsq_simple #(.DEPTH(8), .ROB_ID_W(5)) dut (
        .clk(clk), .rst_aL(rst_aL),
        .dispatch_ready(dispatch_ready), .dispatch_valid(dispatch_valid),
        .dispatch_is_store(dispatch_is_store), .dispatch_width(dispatch_width),
        .dispatch_unsigned(dispatch_unsigned), .dispatch_rob_id(dispatch_rob_id),
        .dispatch_imm(dispatch_imm),
        .dispatch_base_ready(dispatch_base_ready), .dispatch_base_tag(dispatch_base_tag),
        .dispatch_base_val(dispatch_base_val),
        .dispatch_sdata_ready(dispatch_sdata_ready), .dispatch_sdata_tag(dispatch_sdata_tag),
        .dispatch_sdata_val(dispatch_sdata_val),
        .alu_broadcast_valid(alu_broadcast_valid), .alu_broadcast_rob_id(alu_broadcast_rob_id),
        .alu_broadcast_reg_data(alu_broadcast_reg_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_is_store(mem_req_is_store),
        .mem_req_width(mem_req_width), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .ld_broadcast_valid(ld_broadcast_valid), .ld_broadcast_rob_id(ld_broadcast_rob_id),
        .ld_broadcast_data(ld_broadcast_data),
        .st_done_valid(st_done_valid), .st_done_rob_id(st_done_rob_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic st, input logic [1:0] w, input logic uns, input logic [4:0] rob,
                            input logic [11:0] imm, input logic brdy, input logic [4:0] btag,
                            input logic [31:0] bval, input logic srdy, input logic [4:0] stag,
                            input logic [31:0] sval);
        dispatch_valid = 1'b1;
        dispatch_is_store = st;
        dispatch_width = w;
        dispatch_unsigned = uns;
        dispatch_rob_id = rob;
        dispatch_imm = imm;
        dispatch_base_ready = brdy;
        dispatch_base_tag = btag;
        dispatch_base_val = bval;
        dispatch_sdata_ready = srdy;
        dispatch_sdata_tag = stag;
        dispatch_sdata_val = sval;
        step();
        dispatch_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, {31'b0, mem_req_valid}, 32'd1);
    endtask

    task automatic accept();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_data = d;
        step();
        mem_resp_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [1:0] w, input logic uns, input logic [4:0] rob,
                        input logic [11:0] imm, input logic [31:0] base, input logic [31:0] exp_addr,
                        input logic [31:0] resp, input logic [31:0] exp_data);
        dispatch(1'b0, w, uns, rob, imm, 1'b1, 5'd0, base, 1'b0, 5'd0, 32'd0);
        wait_req(tag);
        check({tag, "_addr"}, mem_req_addr, exp_addr);
        check({tag, "_is_store"}, {31'b0, mem_req_is_store}, 32'd0);
        accept();
        respond(resp);
        check({tag, "_ld_valid"}, {31'b0, ld_broadcast_valid}, 32'd1);
        check({tag, "_ld_rob"}, {27'b0, ld_broadcast_rob_id}, {27'b0, rob});
        check({tag, "_ld_data"}, ld_broadcast_data, exp_data);
        step();
        check({tag, "_ld_pulse"}, {31'b0, ld_broadcast_valid}, 32'd0);
    endtask

    initial begin
        dispatch_valid = 0; dispatch_is_store = 0; dispatch_width = 0; dispatch_unsigned = 0;
        dispatch_rob_id = 0; dispatch_imm = 0; dispatch_base_ready = 0; dispatch_base_tag = 0;
        dispatch_base_val = 0; dispatch_sdata_ready = 0; dispatch_sdata_tag = 0; dispatch_sdata_val = 0;
        alu_broadcast_valid = 0; alu_broadcast_rob_id = 0; alu_broadcast_reg_data = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        step();
        step();
        check("rst_ready", {31'b0, dispatch_ready}, 32'd1);
        check("rst_req", {31'b0, mem_req_valid}, 32'd0);
        check("rst_ld", {31'b0, ld_broadcast_valid}, 32'd0);
        check("rst_st", {31'b0, st_done_valid}, 32'd0);
        rst_aL = 1'b1;
        step();

        load("ldw", 2'b10, 1'b0, 5'd1, 12'hFFC, 32'h0000_1000, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load("ldb_s", 2'b00, 1'b0, 5'd2, 12'h000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0080, 32'hFFFF_FF80);
        load("ldb_u", 2'b00, 1'b1, 5'd4, 12'h000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080);
        load("ldh_s", 2'b01, 1'b0, 5'd8, 12'h001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_8001, 32'hFFFF_8001);

        // Store waits on sdata tag 3, then issues with the masked broadcast value.
        dispatch(1'b1, 2'b00, 1'b0, 5'd6, 12'h7FF, 1'b1, 5'd0, 32'h0000_2000, 1'b0, 5'd3, 32'd0);
        step();
        step();
        check("st_blocked", {31'b0, mem_req_valid}, 32'd0);
        alu_broadcast_valid = 1'b1;
        alu_broadcast_rob_id = 5'd3;
        alu_broadcast_reg_data = 32'hABCD_0055;
        step();
        alu_broadcast_valid = 1'b0;
        wait_req("st");
        check("st_addr", mem_req_addr, 32'h0000_27FF);
        check("st_wdata", mem_req_wdata, 32'h0000_0055);
        check("st_is_store", {31'b0, mem_req_is_store}, 32'd1);
        check("st_width", {30'b0, mem_req_width}, 32'd0);
        step();
        step();
        check("st_req_held", {31'b0, mem_req_valid}, 32'd1);
        check("st_wdata_held", mem_req_wdata, 32'h0000_0055);
        accept();
        check("st_done", {31'b0, st_done_valid}, 32'd1);
        check("st_done_rob", {27'b0, st_done_rob_id}, 32'd6);
        check("st_req_drop", {31'b0, mem_req_valid}, 32'd0);
        step();
        check("st_done_pulse", {31'b0, st_done_valid}, 32'd0);

        // Fill all 8 entries with loads blocked on tag 20; a 9th dispatch must be dropped.
        for (int i = 0; i < 8; i++) begin
            check("fill_ready", {31'b0, dispatch_ready}, 32'd1);
            dispatch(1'b0, 2'b10, 1'b0, 5'(10 + i), 12'(4 * i), 1'b0, 5'd20, 32'd0, 1'b0, 5'd0, 32'd0);
        end
        check("full_ready", {31'b0, dispatch_ready}, 32'd0);
        dispatch(1'b0, 2'b10, 1'b0, 5'd9, 12'd0, 1'b1, 5'd0, 32'h0000_9000, 1'b0, 5'd0, 32'd0);
        alu_broadcast_valid = 1'b1;
        alu_broadcast_rob_id = 5'd20;
        alu_broadcast_reg_data = 32'h0000_3000;
        step();
        alu_broadcast_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_req("drain");
            check("drain_addr", mem_req_addr, 32'h0000_3000 + 32'(4 * i));
            accept();
            if (i == 0) check("full_before_pop", {31'b0, dispatch_ready}, 32'd0);
            respond(32'h1000 + 32'(i));
            if (i == 0) check("ready_after_pop", {31'b0, dispatch_ready}, 32'd1);
            check("drain_rob", {27'b0, ld_broadcast_rob_id}, 32'(10 + i));
            check("drain_data", ld_broadcast_data, 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) step();
        check("ninth_dropped", {31'b0, mem_req_valid}, 32'd0);

        // Base tag satisfied by the same-cycle broadcast.
        alu_broadcast_valid = 1'b1;
        alu_broadcast_rob_id = 5'd5;
        alu_broadcast_reg_data = 32'h0000_4000;
        dispatch(1'b0, 2'b10, 1'b0, 5'd7, 12'h008, 1'b0, 5'd5, 32'hDEAD_0000, 1'b0, 5'd0, 32'd0);
        alu_broadcast_valid = 1'b0;
        wait_req("bypass");
        check("bypass_addr", mem_req_addr, 32'h0000_4008);
        accept();
        respond(32'h0000_0077);
        check("bypass_rob", {27'b0, ld_broadcast_rob_id}, 32'd7);

        // Reset while waiting for a response; the late response must be ignored.
        dispatch(1'b0, 2'b10, 1'b0, 5'd12, 12'h000, 1'b1, 5'd0, 32'h0000_5000, 1'b0, 5'd0, 32'd0);
        wait_req("rst_mid");
        accept();
        #2 rst_aL = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, mem_req_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, dispatch_ready}, 32'd1);
        step();
        rst_aL = 1'b1;
        step();
        respond(32'h0000_00AA);
        check("late_resp_ld", {31'b0, ld_broadcast_valid}, 32'd0);
        step();
        step();
        check("late_resp_ld2", {31'b0, ld_broadcast_valid}, 32'd0);
        check("rst_mid_empty", {31'b0, mem_req_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
